// File: rtl/serpent_pkg.sv
// serpent_pkg: shared constants and types for the Serpent subkey store.
//   NUM_SUBKEYS - number of stored round subkeys (K0..K32)
//   KEY_W       - subkey width in bits
//   ADDR_W      - subkey index width
//   subkey_t    - one 128-bit round subkey
//   addr_t      - subkey index
//   state_t     - store FSM states (ZERO only reachable with SERPENT_SUBKEY_ZEROIZE_EN)
package serpent_pkg;

    localparam int NUM_SUBKEYS = 33;
    localparam int KEY_W       = 128;
    localparam int ADDR_W      = 6;

    typedef logic [KEY_W-1:0]  subkey_t;
    typedef logic [ADDR_W-1:0] addr_t;

    localparam addr_t LAST_IDX = addr_t'(NUM_SUBKEYS - 1);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        ZERO
    } state_t;

    // Next stream index: ascending for encryption, descending for decryption.
    function automatic addr_t step_idx(addr_t idx, logic decrypt);
        return decrypt ? idx - addr_t'(1) : idx + addr_t'(1);
    endfunction

endpackage

// File: rtl/serpent_subkey_store_if.sv
// serpent_subkey_store_if: subkey write bus, stream handshake and status
// signals of the Serpent subkey store.
//   master - key schedule / round engine side (drives i_*, observes o_*)
//   slave  - the subkey store (observes i_*, drives o_*)
interface serpent_subkey_store_if;
    import serpent_pkg::*;

    logic    i_load_start;
    logic    i_wr_valid;
    addr_t   i_wr_addr;
    subkey_t i_wr_data;
    logic    i_start;
    logic    i_decrypt;
    logic    i_rk_ready;
    logic    o_rk_valid;
    subkey_t o_rk_data;
    addr_t   o_rk_index;
    logic    o_keys_ready;
    logic    o_busy;
    logic    o_done;
    logic    o_err;

    modport master (
        output i_load_start, i_wr_valid, i_wr_addr, i_wr_data,
               i_start, i_decrypt, i_rk_ready,
        input  o_rk_valid, o_rk_data, o_rk_index,
               o_keys_ready, o_busy, o_done, o_err
    );

    modport slave (
        input  i_load_start, i_wr_valid, i_wr_addr, i_wr_data,
               i_start, i_decrypt, i_rk_ready,
        output o_rk_valid, o_rk_data, o_rk_index,
               o_keys_ready, o_busy, o_done, o_err
    );

endinterface

// File: rtl/serpent_subkey_ram.sv
// serpent_subkey_ram: 33 x 128 register file, one write port and one
// registered read port.
//   clk, rst         - clock, synchronous active-high reset (read register only)
//   wr_en/addr/data  - write port, stored on the rising edge
//   rd_addr/rd_data  - read port; rd_data is mem[rd_addr] one cycle later
module serpent_subkey_ram
    import serpent_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    wr_en,
    input  addr_t   wr_addr,
    input  subkey_t wr_data,
    input  addr_t   rd_addr,
    output subkey_t rd_data
);

    subkey_t mem [NUM_SUBKEYS];

    // NOTE: the storage array has no reset (its contents are don't-care);
    // only the read register is reset so the output reads 0 after reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/serpent_subkey_store.sv
// serpent_subkey_store: captures the 33 Serpent round subkeys from the key
// schedule, tracks which are present, and streams them to the round engine
// (ascending for encryption, descending for decryption).
//   i_clk, i_rst - clock, synchronous active-high reset
//   bus          - serpent_subkey_store_if.slave: write bus, start request,
//                  valid/ready subkey stream, keys_ready/busy/done/err status
// Optional feature: define SERPENT_SUBKEY_ZEROIZE_EN to make i_load_start in
// IDLE wipe all entries to zero (ZERO state, 33 cycles, o_busy high).
module serpent_subkey_store
    import serpent_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    serpent_subkey_store_if.slave bus
);

    state_t                 state;
    logic [NUM_SUBKEYS-1:0] bitmap;
    logic [NUM_SUBKEYS-1:0] bitmap_next;
    logic                   decrypt;
    addr_t                  idx;
    addr_t                  rd_addr;
    logic                   rk_valid, keys_ready, busy, done, err;

    logic    in_idle, addr_ok, wr_en, start_ok, handshake, last_idx, err_next;
    logic    ram_we;
    addr_t   ram_waddr;
    subkey_t ram_wdata;

    assign in_idle   = (state == IDLE);
    assign addr_ok   = (bus.i_wr_addr <= LAST_IDX);
    assign handshake = rk_valid && bus.i_rk_ready;
    assign last_idx  = decrypt ? (idx == '0) : (idx == LAST_IDX);
    // A simultaneous load start takes priority over a start request.
    assign start_ok  = in_idle && bus.i_start && !bus.i_load_start && keys_ready;

`ifdef SERPENT_SUBKEY_ZEROIZE_EN
    addr_t zero_idx;

    // A write alongside the load start would be wiped by the zeroize pass,
    // so it is rejected rather than marked present.
    assign wr_en     = in_idle && bus.i_wr_valid && addr_ok && !bus.i_load_start;
    assign ram_we    = wr_en || (state == ZERO);
    assign ram_waddr = (state == ZERO) ? zero_idx : bus.i_wr_addr;
    assign ram_wdata = (state == ZERO) ? '0 : bus.i_wr_data;
`else
    assign wr_en     = in_idle && bus.i_wr_valid && addr_ok;
    assign ram_we    = wr_en;
    assign ram_waddr = bus.i_wr_addr;
    assign ram_wdata = bus.i_wr_data;
`endif

    // Any write or start that was not taken is an error.
    assign err_next = (bus.i_wr_valid && !wr_en) || (bus.i_start && !start_ok);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        bitmap_next = bitmap;
        if (in_idle && bus.i_load_start) begin
            bitmap_next = '0;
        end
        if (wr_en) begin
            bitmap_next[bus.i_wr_addr] = 1'b1;
        end
    end

    // Read address is the index that will be shown next cycle, so the
    // registered RAM output lines up with the registered index.
    always_comb begin
        rd_addr = idx;
        if (start_ok) begin
            rd_addr = bus.i_decrypt ? LAST_IDX : '0;
        end else if (state == STREAM && handshake && !last_idx) begin
            rd_addr = step_idx(idx, decrypt);
        end
    end

    serpent_subkey_ram u_ram (
        .clk     (i_clk),
        .rst     (i_rst),
        .wr_en   (ram_we),
        .wr_addr (ram_waddr),
        .wr_data (ram_wdata),
        .rd_addr (rd_addr),
        .rd_data (bus.o_rk_data)
    );

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            bitmap     <= '0;
            keys_ready <= 1'b0;
            decrypt    <= 1'b0;
            idx        <= '0;
            rk_valid   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
`ifdef SERPENT_SUBKEY_ZEROIZE_EN
            zero_idx   <= '0;
`endif
        end else begin
            bitmap     <= bitmap_next;
            keys_ready <= &bitmap_next;
            err        <= err_next;
            done       <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        decrypt  <= bus.i_decrypt;
                        idx      <= rd_addr;
                        rk_valid <= 1'b1;
                        busy     <= 1'b1;
                        state    <= STREAM;
                    end
`ifdef SERPENT_SUBKEY_ZEROIZE_EN
                    else if (bus.i_load_start) begin
                        zero_idx <= '0;
                        busy     <= 1'b1;
                        state    <= ZERO;
                    end
`endif
                end
                STREAM: begin
                    if (handshake) begin
                        if (last_idx) begin
                            rk_valid <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            idx <= rd_addr;
                        end
                    end
                end
`ifdef SERPENT_SUBKEY_ZEROIZE_EN
                ZERO: begin
                    if (zero_idx == LAST_IDX) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        zero_idx <= zero_idx + addr_t'(1);
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_rk_valid   = rk_valid;
    assign bus.o_rk_index   = idx;
    assign bus.o_keys_ready = keys_ready;
    assign bus.o_busy       = busy;
    assign bus.o_done       = done;
    assign bus.o_err        = err;

endmodule
